// File: rtl/tych_rx_pkg.sv
// Shared types for the tych receive path.
//   mac_avlrx_t : one Avalon-ST RX beat from MAC 0 (only the fields the monitor uses).
package tych_rx_pkg;

    typedef struct packed {
        logic [511:0] data;   // byte 0 is data[511:504]
        logic         valid;
        logic         sop;
        logic         eop;
        logic         error;
    } mac_avlrx_t;

endpackage

// File: rtl/tych_rx_frame_mon.sv
// tych_rx_frame_mon: receive-side frame monitor for the MAC 0 RX stream.
// Sinks every beat (no backpressure), checks SOP/EOP framing and frame length, queues one
// Ethernet-header descriptor per completed frame and keeps saturating statistics.
//
// Ports:
//   clk_i            core clock, rising edge
//   rst_ni           synchronous active-low reset
//   mac_rx_i         RX beat (data/valid/sop/eop/error)
//   desc_valid_o     descriptor FIFO head is valid
//   desc_ready_i     consumer accepts the head descriptor
//   desc_dst_o       destination MAC of the frame
//   desc_src_o       source MAC of the frame
//   desc_type_o      EtherType of the frame
//   desc_beats_o     beats in the frame, saturating at 255
//   desc_status_o    [0] MAC error, [1] oversize, [2] always 0
//   cnt_clr_i        synchronous clear of all counters
//   cnt_good_o       frames completed with clean status
//   cnt_bad_o        frames completed with non-zero status
//   cnt_framing_o    orphan beats plus aborted frames
//   cnt_drop_o       descriptors lost to a full FIFO
module tych_rx_frame_mon
    import tych_rx_pkg::*;
#(
    parameter int unsigned MAX_BEATS  = 24,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  mac_avlrx_t  mac_rx_i,
    output logic        desc_valid_o,
    input  logic        desc_ready_i,
    output logic [47:0] desc_dst_o,
    output logic [47:0] desc_src_o,
    output logic [15:0] desc_type_o,
    output logic [7:0]  desc_beats_o,
    output logic [2:0]  desc_status_o,
    input  logic        cnt_clr_i,
    output logic [31:0] cnt_good_o,
    output logic [31:0] cnt_bad_o,
    output logic [31:0] cnt_framing_o,
    output logic [31:0] cnt_drop_o
);

    localparam int unsigned PtrW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [7:0]  MaxBeats8 = 8'(MAX_BEATS);
    localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] etype;
        logic [7:0]  beats;
        logic [2:0]  status;
    } desc_t;

    typedef enum logic [1:0] {StIdle, StInPkt, StOversize} state_e;

    // ------------------------------------------------------------------
    // Frame tracking
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [47:0] dst_q, dst_d;
    logic [47:0] src_q, src_d;
    logic [15:0] etype_q, etype_d;
    logic [7:0]  beats_q, beats_d;
    logic        err_q, err_d;
    logic        ovs_q, ovs_d;

    logic        cpl;          // a frame completes this cycle
    logic        framing_inc;  // orphan beat or aborted frame
    desc_t       cpl_desc;
    logic [7:0]  beats_inc;

    assign beats_inc = (beats_q == 8'hFF) ? 8'hFF : beats_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        dst_d       = dst_q;
        src_d       = src_q;
        etype_d     = etype_q;
        beats_d     = beats_q;
        err_d       = err_q;
        ovs_d       = ovs_q;
        cpl         = 1'b0;
        framing_inc = 1'b0;

        if (mac_rx_i.valid) begin
            if (mac_rx_i.sop) begin
                // An SOP inside an open frame aborts it silently apart from the framing count,
                // then starts a fresh frame exactly as from idle.
                framing_inc = (state_q != StIdle);
                dst_d       = mac_rx_i.data[511:464];
                src_d       = mac_rx_i.data[463:416];
                etype_d     = mac_rx_i.data[415:400];
                beats_d     = 8'd1;
                err_d       = mac_rx_i.error;
                ovs_d       = 1'b0;
                cpl         = mac_rx_i.eop;
                state_d     = mac_rx_i.eop ? StIdle : StInPkt;
            end else begin
                case (state_q)
                    StIdle: begin
                        framing_inc = 1'b1;
                    end
                    StInPkt: begin
                        beats_d = beats_inc;
                        err_d   = err_q | mac_rx_i.error;
                        if (mac_rx_i.eop) begin
                            cpl     = 1'b1;
                            state_d = StIdle;
                        end else if (beats_inc == MaxBeats8) begin
                            // Legal length used up and no EOP yet: more beats must follow.
                            ovs_d   = 1'b1;
                            state_d = StOversize;
                        end
                    end
                    StOversize: begin
                        beats_d = beats_inc;
                        err_d   = err_q | mac_rx_i.error;
                        if (mac_rx_i.eop) begin
                            cpl     = 1'b1;
                            state_d = StIdle;
                        end
                    end
                    default: begin
                        state_d = StIdle;
                    end
                endcase
            end
        end

        cpl_desc = '{dst: dst_d, src: src_d, etype: etype_d, beats: beats_d,
                     status: {1'b0, ovs_d, err_d}};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            dst_q   <= '0;
            src_q   <= '0;
            etype_q <= '0;
            beats_q <= '0;
            err_q   <= 1'b0;
            ovs_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
            etype_q <= etype_d;
            beats_q <= beats_d;
            err_q   <= err_d;
            ovs_q   <= ovs_d;
        end
    end

    // ------------------------------------------------------------------
    // Descriptor FIFO
    // ------------------------------------------------------------------
    desc_t           mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic            fifo_full, pop, push, drop;
    desc_t           head;

    assign fifo_full = (count_q == DepthCnt);
    assign pop       = (count_q != '0) && desc_ready_i;
    // A pop in the same cycle frees a slot for the push.
    assign push      = cpl && (!fifo_full || pop);
    assign drop      = cpl && fifo_full && !pop;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cpl_desc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign desc_valid_o  = (count_q != '0);
    assign desc_dst_o    = head.dst;
    assign desc_src_o    = head.src;
    assign desc_type_o   = head.etype;
    assign desc_beats_o  = head.beats;
    assign desc_status_o = head.status;

    // ------------------------------------------------------------------
    // Statistics counters (saturating, clear beats increment)
    // ------------------------------------------------------------------
    logic        good_inc, bad_inc;
    logic [31:0] cnt_good_q, cnt_bad_q, cnt_framing_q, cnt_drop_q;

    assign good_inc = cpl && (cpl_desc.status == 3'b000);
    assign bad_inc  = cpl && (cpl_desc.status != 3'b000);

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
        return (inc && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_ni || cnt_clr_i) begin
            cnt_good_q    <= '0;
            cnt_bad_q     <= '0;
            cnt_framing_q <= '0;
            cnt_drop_q    <= '0;
        end else begin
            cnt_good_q    <= sat_inc(cnt_good_q, good_inc);
            cnt_bad_q     <= sat_inc(cnt_bad_q, bad_inc);
            cnt_framing_q <= sat_inc(cnt_framing_q, framing_inc);
            cnt_drop_q    <= sat_inc(cnt_drop_q, drop);
        end
    end

    assign cnt_good_o    = cnt_good_q;
    assign cnt_bad_o     = cnt_bad_q;
    assign cnt_framing_o = cnt_framing_q;
    assign cnt_drop_o    = cnt_drop_q;

endmodule

// File: tb/tb_tych_rx_frame_mon.sv
// Randomised and directed bench for tych_rx_frame_mon with a frame-level reference model and
// a descriptor scoreboard checked by an independent monitor.
module tb_tych_rx_frame_mon;
    import tych_rx_pkg::*;

    localparam int unsigned MaxBeats  = 24;
    localparam int unsigned FifoDepth = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    mac_avlrx_t  rx;
    logic        desc_valid, desc_ready, cnt_clr;
    logic [47:0] desc_dst, desc_src;
    logic [15:0] desc_type;
    logic [7:0]  desc_beats;
    logic [2:0]  desc_status;
    logic [31:0] cnt_good, cnt_bad, cnt_framing, cnt_drop;

    always #5 clk = ~clk;

    tych_rx_frame_mon #(
        .MAX_BEATS (MaxBeats),
        .FIFO_DEPTH(FifoDepth)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .mac_rx_i     (rx),
        .desc_valid_o (desc_valid),
        .desc_ready_i (desc_ready),
        .desc_dst_o   (desc_dst),
        .desc_src_o   (desc_src),
        .desc_type_o  (desc_type),
        .desc_beats_o (desc_beats),
        .desc_status_o(desc_status),
        .cnt_clr_i    (cnt_clr),
        .cnt_good_o   (cnt_good),
        .cnt_bad_o    (cnt_bad),
        .cnt_framing_o(cnt_framing),
        .cnt_drop_o   (cnt_drop)
    );

    typedef struct packed {
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] etype;
        logic [7:0]  beats;
        logic [2:0]  status;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: frame-level view of the stream
    bit          m_open;
    int          m_len;
    bit          m_err;
    logic [47:0] m_dst, m_src;
    logic [15:0] m_type;
    int          m_occ;
    logic [31:0] m_good, m_bad, m_framing, m_drop;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] sat(input logic [31:0] v, input bit inc);
        return (inc && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

    task automatic model_reset();
        m_open = 0; m_len = 0; m_err = 0; m_occ = 0;
        m_good = 0; m_bad = 0; m_framing = 0; m_drop = 0;
        sbq.delete();
    endtask

    // Applied at each rising edge with the inputs the DUT just sampled.
    task automatic model_edge();
        bit   cpl, pop, inc_g, inc_b, inc_f, inc_d;
        exp_t e;
        cpl = 0; inc_g = 0; inc_b = 0; inc_f = 0; inc_d = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        pop = (m_occ > 0) && desc_ready;
        if (rx.valid) begin
            if (rx.sop) begin
                if (m_open) inc_f = 1;
                m_open = 1;
                m_dst  = rx.data[511:464];
                m_src  = rx.data[463:416];
                m_type = rx.data[415:400];
                m_len  = 1;
                m_err  = rx.error;
                cpl    = rx.eop;
            end else if (!m_open) begin
                inc_f = 1;
            end else begin
                m_len++;
                m_err = m_err | rx.error;
                cpl   = rx.eop;
            end
        end
        if (cpl) begin
            m_open   = 0;
            e.dst    = m_dst;
            e.src    = m_src;
            e.etype  = m_type;
            e.beats  = (m_len > 255) ? 8'd255 : 8'(m_len);
            e.status = {1'b0, (m_len > int'(MaxBeats)), m_err};
            if (e.status == 3'b000) inc_g = 1; else inc_b = 1;
            if (m_occ == int'(FifoDepth) && !pop) begin
                inc_d = 1;
            end else begin
                sbq.push_back(e);
                m_occ++;
            end
        end
        if (pop) m_occ--;
        if (cnt_clr) begin
            m_good = 0; m_bad = 0; m_framing = 0; m_drop = 0;
        end else begin
            m_good    = sat(m_good, inc_g);
            m_bad     = sat(m_bad, inc_b);
            m_framing = sat(m_framing, inc_f);
            m_drop    = sat(m_drop, inc_d);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("desc_valid", desc_valid, (m_occ > 0));
        chk("cnt_good", cnt_good, m_good);
        chk("cnt_bad", cnt_bad, m_bad);
        chk("cnt_framing", cnt_framing, m_framing);
        chk("cnt_drop", cnt_drop, m_drop);
    endtask

    // Monitor: every accepted descriptor must match the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && desc_valid && desc_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_desc actual=valid required=empty");
            end else begin
                e = sbq.pop_front();
                chk("desc_dst", desc_dst, e.dst);
                chk("desc_src", desc_src, e.src);
                chk("desc_type", desc_type, e.etype);
                chk("desc_beats", desc_beats, e.beats);
                chk("desc_status", desc_status, e.status);
            end
        end
    end

    function automatic logic [511:0] rnd_data();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [511:0] hdr(input logic [47:0] dst, input logic [47:0] src,
                                         input logic [15:0] t);
        logic [511:0] d;
        d = rnd_data();
        d[511:464] = dst;
        d[463:416] = src;
        d[415:400] = t;
        return d;
    endfunction

    task automatic beat(input bit sop, input bit eop, input bit err, input logic [511:0] d);
        rx.valid = 1'b1;
        rx.sop   = sop;
        rx.eop   = eop;
        rx.error = err;
        rx.data  = d;
        cycle();
        rx.valid = 1'b0;
    endtask

    task automatic idle(input int n);
        rx.valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drain();
        desc_ready = 1'b1;
        idle(FifoDepth + 1);
        desc_ready = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        rx         = '0;
        desc_ready = 1'b0;
        cnt_clr    = 1'b0;
        model_reset();
        idle(2);
        rst_n = 1'b1;
        idle(1);
        chk("reset_desc_valid", desc_valid, 0);
        chk("reset_cnt_good", cnt_good, 0);
        chk("reset_cnt_framing", cnt_framing, 0);

        // Single-beat frame
        beat(1, 1, 0, hdr(48'h0011_2233_4455, 48'hAABB_CCDD_EEFF, 16'h0800));
        chk("single_valid", desc_valid, 1);
        chk("single_dst", desc_dst, 48'h0011_2233_4455);
        chk("single_src", desc_src, 48'hAABB_CCDD_EEFF);
        chk("single_type", desc_type, 16'h0800);
        chk("single_beats", desc_beats, 1);
        chk("single_status", desc_status, 0);
        chk("single_good", cnt_good, 1);
        drain();

        // 3-beat frame, error on beat 2
        beat(1, 0, 0, hdr(48'h1, 48'h2, 16'h86DD));
        beat(0, 0, 1, rnd_data());
        beat(0, 1, 0, rnd_data());
        chk("err3_beats", desc_beats, 3);
        chk("err3_status", desc_status, 3'b001);
        chk("err3_bad", cnt_bad, 1);
        chk("err3_good", cnt_good, 1);
        drain();

        // 30-beat oversize frame
        beat(1, 0, 0, hdr(48'h3, 48'h4, 16'h0806));
        for (int i = 2; i <= 30; i++) beat(0, (i == 30), 0, rnd_data());
        chk("ovs_beats", desc_beats, 30);
        chk("ovs_status", desc_status, 3'b010);
        chk("ovs_bad", cnt_bad, 2);
        drain();

        // 24 beats exactly is still legal
        beat(1, 0, 0, hdr(48'h5, 48'h6, 16'h0800));
        for (int i = 2; i <= 24; i++) beat(0, (i == 24), 0, rnd_data());
        chk("max_status", desc_status, 3'b000);
        drain();

        // Orphan, then SOP at beat 2 of an open frame
        beat(0, 0, 0, rnd_data());
        beat(1, 0, 0, hdr(48'h7, 48'h8, 16'h0800));
        beat(1, 0, 0, hdr(48'h9, 48'hA, 16'h0800));
        beat(0, 1, 0, rnd_data());
        chk("abort_framing", cnt_framing, 2);
        chk("abort_dst", desc_dst, 48'h9);
        chk("abort_beats", desc_beats, 2);
        drain();

        // FIFO overflow: 6 back-to-back single-beat frames, no consumer
        cnt_clr = 1'b1;
        idle(1);
        cnt_clr = 1'b0;
        for (int i = 0; i < 6; i++) beat(1, 1, 0, hdr(48'(i + 16), 48'h0, 16'h0800));
        chk("ovf_drop", cnt_drop, 2);
        chk("ovf_good", cnt_good, 6);
        desc_ready = 1'b1;
        idle(4);
        chk("ovf_emptied", desc_valid, 0);
        desc_ready = 1'b0;

        // Clear wins over a completing frame, then reset mid-frame
        cnt_clr = 1'b1;
        beat(1, 1, 0, hdr(48'hB, 48'hC, 16'h0800));
        cnt_clr = 1'b0;
        chk("clr_good", cnt_good, 0);
        beat(1, 0, 0, hdr(48'hD, 48'hE, 16'h0800));
        beat(0, 0, 0, rnd_data());
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        chk("rst_valid", desc_valid, 0);
        chk("rst_good", cnt_good, 0);
        beat(0, 1, 0, rnd_data());
        chk("rst_orphan", cnt_framing, 1);

        // Beat count saturation
        beat(1, 0, 0, hdr(48'hF, 48'h10, 16'h0800));
        for (int i = 2; i <= 260; i++) beat(0, (i == 260), 0, rnd_data());
        chk("sat_beats", desc_beats, 255);
        chk("sat_status", desc_status, 3'b010);
        drain();

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            rx.valid   = ($urandom % 4) != 0;
            rx.sop     = ($urandom % 6) == 0;
            rx.eop     = ($urandom % 4) == 0;
            rx.error   = ($urandom % 16) == 0;
            rx.data    = rnd_data();
            desc_ready = ($urandom % 3) != 0;
            cnt_clr    = ($urandom % 300) == 0;
            rst_n      = ($urandom % 800) != 0;
            cycle();
        end
        rst_n   = 1'b1;
        cnt_clr = 1'b0;
        drain();
        chk("scoreboard_drained", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tych_rx_frame_mon.md
# tych_rx_frame_mon

Receive-side frame monitor for the MAC 0 Avalon-ST RX stream (`mac_avlrx_t`) entering `tych_core`. It is the receive counterpart of the core's `mac_avltx_t` transmit path. The block:
- sinks every RX beat without backpressure,
- checks SOP/EOP framing and frame length,
- extracts the Ethernet header of each frame into a descriptor FIFO with a valid/ready handshake,
- keeps saturating statistics counters for the core's control logic.

## Interface
Parameters:
- MAX_BEATS, 24, longest legal frame in 64-byte beats (1536 B); range 2..255
- FIFO_DEPTH, 4, descriptor FIFO entries; power of two, ≥2

Ports:
- clk  input  1  core clock; all logic on rising edge
- rst  input  1  synchronous, active-low reset
- mac_rx  input  mac_avlrx_t  RX beat; fields used: data[511:0], valid, sop, eop, error
- desc_valid  output  1  FIFO head holds a descriptor
- desc_ready  input  1  consumer accepts head descriptor
- desc_dst  output  48  destination MAC = data[511:464] of SOP beat
- desc_src  output  48  source MAC = data[463:416] of SOP beat
- desc_type  output  16  EtherType = data[415:400] of SOP beat
- desc_beats  output  8  beats in frame, including SOP and EOP beats; saturates at 255
- desc_status  output  3  [0] MAC error seen on any beat, [1] oversize, [2] reserved, always 0
- cnt_clr  input  1  synchronous clear of all four counters
- cnt_good  output  32  frames completed with desc_status == 0
- cnt_bad  output  32  frames completed with desc_status != 0
- cnt_framing  output  32  framing violations
- cnt_drop  output  32  descriptors lost to a full FIFO

## Operation
- Beat = cycle with mac_rx.valid=1. Every beat is consumed. Data byte 0 is data[511:504].
- States: IDLE, IN_PKT, OVERSIZE.
- IDLE, beat with sop=1:
  - Capture header fields, set beats=1, and set the error flag from mac_rx.error.
  - eop=1: the frame completes this cycle.
  - Otherwise go to IN_PKT.
- IDLE, beat with sop=0: orphan beat. Increment cnt_framing (once per orphan beat) and discard it. Stay in IDLE.
- IN_PKT, beat with sop=0:
  - Increment beats and OR mac_rx.error into the error flag.
  - eop=1: complete the frame and go to IDLE.
  - Else, if beats reaches MAX_BEATS: set the oversize flag and go to OVERSIZE.
- OVERSIZE: keep counting beats (saturating) and OR in errors. eop=1 completes the frame with oversize=1 and returns to IDLE.
- IN_PKT or OVERSIZE, beat with sop=1:
  - The current frame is aborted. It produces no descriptor and no good/bad count. Increment cnt_framing.
  - The beat is then handled exactly as an SOP beat in IDLE, including an SOP+EOP single-beat frame.
- Frame completion:
  - Push the descriptor {dst, src, type, beats, status} into the FIFO.
  - Increment cnt_good or cnt_bad.
  - If the FIFO is full, drop the descriptor and increment cnt_drop. The good/bad count is still updated.
- FIFO:
  - Outputs show the head entry. Pop on desc_valid & desc_ready.
  - A push and a pop in the same cycle when full both succeed; nothing is dropped.
  - Output values when desc_valid=0 are don't-care.
- Counters:
  - 32-bit, saturate at 0xFFFFFFFF.
  - cnt_clr wins over a simultaneous increment; the result is 0.
- Reset:
  - State IDLE; FIFO empty; desc_valid=0; all counters 0.
  - Any partially received frame is discarded, with no count.
  - A non-SOP beat arriving after reset is treated as an orphan.

## Timing
- SOP/EOP/completion beat at cycle N:
  - Descriptor is written at the end of N. desc_valid=1 from N+1 if the FIFO was empty.
  - Counters show the new value from N+1.
- Framing-violation count is visible from N+1.
- Pop at cycle N: the next entry (or desc_valid=0) is shown from N+1.
- Back-to-back single-beat frames every cycle are supported; one push per cycle at most.
- No combinational path from mac_rx to any output, nor from desc_ready to any output.

## Test plan
- Single-beat frame: SOP+EOP, dst=0x0011_2233_4455, src=0xAABB_CCDD_EEFF, type=0x0800 -> the next cycle shows desc_valid=1, those fields, beats=1, status=0, cnt_good=1.
- 3-beat frame with error=1 on beat 2 -> beats=3, status=3'b001, cnt_bad=1, cnt_good unchanged.
- Frame of 30 beats with MAX_BEATS=24 -> one descriptor with beats=30, status=3'b010, cnt_bad=1.
- Orphan beat in IDLE, then an SOP at beat 2 of an open frame -> cnt_framing=2; only the second frame yields a descriptor.
- 6 single-beat frames with desc_ready=0, FIFO_DEPTH=4 -> 4 descriptors queued in order, cnt_drop=2, cnt_good=6. Then hold desc_ready=1 -> 4 pops on consecutive cycles.
- cnt_clr asserted in the same cycle as a frame completes -> cnt_good reads 0. Then assert rst mid-frame -> desc_valid=0, counters 0, and a following non-SOP beat counts as framing error 1.
